pterm_stream_decoder: RTL and testbench

- Streaming successor to the static product-term decoder: consumes the product-term configuration block one bit per cycle, in bitstream order, as the programmer or JTAG shifter delivers it.
- Assembles each product term's input-enable vector, applying the rule "config bit 1 = input disabled".
- Emits one decoded term per transfer, tagged with lab/macrocell/term indices, over a valid/ready handshake.
- Sits between the bitstream shifter and the logic-array model / PTERM RAM loader.

---
 rtl/pterm_stream_decoder.sv | 162 ++++++++++++++++
 tb/tb_pterm_stream_decoder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pterm_stream_decoder.sv
// Serial product-term configuration decoder: assembles each term's bits as they
// stream in and emits the inverted (enable) vector with lab/macrocell/term tags.
module pterm_stream_decoder #(
   parameter int NUM_LABS             = 2,
   parameter int MACROCELLS_PER_LAB   = 16,
   parameter int PTERMS_PER_MACROCELL = 5,
   parameter int BITS_PER_PTERM       = 88,
   parameter int LAB_W = (NUM_LABS > 1) ? $clog2(NUM_LABS) : 1,
   parameter int MC_W  = (MACROCELLS_PER_LAB > 1) ? $clog2(MACROCELLS_PER_LAB) : 1,
   parameter int PT_W  = (PTERMS_PER_MACROCELL > 1) ? $clog2(PTERMS_PER_MACROCELL) : 1,
   parameter int BIT_W = (BITS_PER_PTERM > 1) ? $clog2(BITS_PER_PTERM) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      in_bit,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [BITS_PER_PTERM-1:0] out_enable,
   output logic [LAB_W-1:0]          out_lab,
   output logic [MC_W-1:0]           out_macrocell,
   output logic [PT_W-1:0]           out_pterm,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t                    state_q, state_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic [PT_W-1:0]           pt_q, pt_d;
   logic [MC_W-1:0]           mc_q, mc_d;
   logic [LAB_W-1:0]          lab_q, lab_d;
   logic [BITS_PER_PTERM-1:0] asm_q, asm_d;
   logic [BITS_PER_PTERM-1:0] oen_q, oen_d;
   logic [LAB_W-1:0]          olab_q, olab_d;
   logic [MC_W-1:0]           omc_q, omc_d;
   logic [PT_W-1:0]           opt_q, opt_d;
   logic                      oval_q, oval_d;
   logic                      done_q;

   logic bit_last, pt_last, mc_last, lab_last;
   logic accept, complete;

   assign bit_last = (bit_q == BIT_W'(BITS_PER_PTERM - 1));
   assign pt_last  = (pt_q  == PT_W'(PTERMS_PER_MACROCELL - 1));
   assign mc_last  = (mc_q  == MC_W'(MACROCELLS_PER_LAB - 1));
   assign lab_last = (lab_q == LAB_W'(NUM_LABS - 1));

   // Only the completing bit waits for the output slot; earlier bits keep flowing.
   assign in_ready = (state_q == LOAD) && !(bit_last && oval_q && !out_ready);
   assign accept   = in_valid && in_ready;
   assign complete = accept && bit_last;

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      pt_d    = pt_q;
      mc_d    = mc_q;
      lab_d   = lab_q;
      asm_d   = asm_q;
      oen_d   = oen_q;
      olab_d  = olab_q;
      omc_d   = omc_q;
      opt_d   = opt_q;
      oval_d  = oval_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               bit_d   = '0;
               pt_d    = '0;
               mc_d    = '0;
               lab_d   = '0;
               asm_d   = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               for (int unsigned i = 0; i < BITS_PER_PTERM; i++) begin
                  if (bit_q == BIT_W'(i)) asm_d[i] = in_bit;
               end
               if (!bit_last) begin
                  bit_d = bit_q + BIT_W'(1);
               end else begin
                  bit_d = '0;
                  if (!pt_last) begin
                     pt_d = pt_q + PT_W'(1);
                  end else begin
                     pt_d = '0;
                     if (!mc_last) begin
                        mc_d = mc_q + MC_W'(1);
                     end else begin
                        mc_d = '0;
                        lab_d = lab_last ? '0 : lab_q + LAB_W'(1);
                        if (lab_last) state_d = DRAIN;
                     end
                  end
               end
            end
         end
         DRAIN: begin
            if (!oval_q || out_ready) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A completing term takes priority over the drain of the previous one.
      if (complete) begin
         oen_d  = ~asm_d;
         olab_d = lab_q;
         omc_d  = mc_q;
         opt_d  = pt_q;
         oval_d = 1'b1;
      end else if (oval_q && out_ready) begin
         oval_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         pt_q    <= '0;
         mc_q    <= '0;
         lab_q   <= '0;
         asm_q   <= '0;
         oen_q   <= '0;
         olab_q  <= '0;
         omc_q   <= '0;
         opt_q   <= '0;
         oval_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         pt_q    <= pt_d;
         mc_q    <= mc_d;
         lab_q   <= lab_d;
         asm_q   <= asm_d;
         oen_q   <= oen_d;
         olab_q  <= olab_d;
         omc_q   <= omc_d;
         opt_q   <= opt_d;
         oval_q  <= oval_d;
         done_q  <= (state_q == DONE);
      end
   end

   assign out_enable    = oen_q;
   assign out_lab       = olab_q;
   assign out_macrocell = omc_q;
   assign out_pterm     = opt_q;
   assign out_valid     = oval_q;
   assign busy          = (state_q != IDLE);
   assign done          = done_q;

endmodule

// File: tb/tb_pterm_stream_decoder.sv
// Bench for pterm_stream_decoder: a term-level scoreboard built from accepted bits
// checks every output transfer, plus directed literal checks.
module tb_pterm_stream_decoder;

   localparam int NL = 2, NM = 2, NP = 2, NB = 4;
   localparam int TERMS = NL * NM * NP;

   logic clock = 1'b0;
   logic reset, start, in_bit, in_valid, in_ready, out_valid, out_ready, busy, done;
   logic [NB-1:0] out_enable;
   logic [0:0] out_lab, out_macrocell, out_pterm;

   pterm_stream_decoder #(
      .NUM_LABS(NL), .MACROCELLS_PER_LAB(NM), .PTERMS_PER_MACROCELL(NP), .BITS_PER_PTERM(NB)
   ) dut (
      .clock(clock), .reset(reset), .start(start), .in_bit(in_bit), .in_valid(in_valid),
      .in_ready(in_ready), .out_enable(out_enable), .out_lab(out_lab),
      .out_macrocell(out_macrocell), .out_pterm(out_pterm), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [NB-1:0] en;
      int lab, mc, pt;
   } term_t;

   term_t expq[$];
   logic [NB-1:0] bitbuf;
   int nbits, kterm, xfers, done_cnt, done_cyc, last_xfer_cyc, cyc;
   int n_cmp = 0, n_bad = 0;
   logic prev_stall;
   logic [NB-1:0] prev_en;
   logic [2:0] prev_idx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clock) cyc++;

   // Scoreboard: every NB accepted bits form a term; its tags follow from its ordinal.
   always @(negedge clock) begin
      if (reset) begin
         expq.delete();
         nbits = 0;
         kterm = 0;
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {out_enable, out_lab, out_macrocell, out_pterm}, {prev_en, prev_idx});
         end
         if (!busy) chk("idle_in_ready", in_ready, 0);
         if (start && !busy) begin
            nbits = 0;
            kterm = 0;
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("unexpected_term", 1, 0);
            end else begin
               term_t t;
               t = expq.pop_front();
               chk("term_enable", out_enable, t.en);
               chk("term_lab", out_lab, t.lab);
               chk("term_mc", out_macrocell, t.mc);
               chk("term_pt", out_pterm, t.pt);
            end
            xfers++;
            last_xfer_cyc = cyc;
         end
         if (in_valid && in_ready) begin
            bitbuf[nbits] = in_bit;
            nbits++;
            if (nbits == NB) begin
               term_t t;
               t.en  = ~bitbuf;
               t.lab = kterm / (NM * NP);
               t.mc  = (kterm / NP) % NM;
               t.pt  = kterm % NP;
               expq.push_back(t);
               kterm++;
               nbits = 0;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_drained", expq.size(), 0);
         end
         prev_stall = out_valid && !out_ready;
         prev_en    = out_enable;
         prev_idx   = {out_lab, out_macrocell, out_pterm};
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      int n = 0;
      in_valid = 1'b1;
      in_bit   = b;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (done_cnt == 0 && n < 300) begin
         tick();
         n++;
      end
      if (done_cnt == 0) chk("done_timeout", 0, 1);
   endtask

   function automatic logic pat_bit(input int val, input int j);
      return logic'((val >> j) & 1);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cyc = 0; xfers = 0; done_cnt = 0; done_cyc = 0; last_xfer_cyc = 0;
      nbits = 0; kterm = 0; prev_stall = 1'b0;
      reset = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_enable", out_enable, 0);
      chk("rst_idx", {out_lab, out_macrocell, out_pterm}, 0);
      reset = 1'b0;

      // Idle: valid bits without start are ignored
      in_valid = 1'b1;
      in_bit   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("idle_ready", in_ready, 0);
         chk("idle_valid", out_valid, 0);
         chk("idle_busy", busy, 0);
         tick();
      end
      in_valid = 1'b0;
      chk("idle_no_terms", xfers, 0);

      // Single term 1,0,0,1 -> enable 0110
      pulse_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      chk("single_valid", out_valid, 1);
      chk("single_enable", out_enable, 4'b0110);
      chk("single_idx", {out_lab, out_macrocell, out_pterm}, 3'b000);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;

      // Full block, term k carries binary k
      xfers = 0; done_cnt = 0;
      pulse_start();
      for (int k = 0; k < TERMS; k++) begin
         for (int j = 0; j < NB; j++) send_bit(pat_bit(k, j));
         if (k == 5) begin
            chk("t5_valid", out_valid, 1);
            chk("t5_enable", out_enable, 4'b1010);
            chk("t5_idx", {out_lab, out_macrocell, out_pterm}, 3'b101);
         end
      end
      wait_done();
      tick(); tick(); tick();
      chk("full_xfers", xfers, TERMS);
      chk("full_done_once", done_cnt, 1);
      chk("full_done_lat", done_cyc - last_xfer_cyc, 2);
      chk("full_busy_after", busy, 0);

      // Backpressure and simultaneous take/complete
      xfers = 0; done_cnt = 0;
      pulse_start();
      for (int j = 0; j < NB; j++) send_bit(pat_bit(0, j));
      out_ready = 1'b0;
      chk("bp_t0_valid", out_valid, 1);
      chk("bp_t0_enable", out_enable, 4'b1111);
      for (int j = 0; j < NB - 1; j++) send_bit(pat_bit(1, j));
      in_valid = 1'b1;
      in_bit   = pat_bit(1, NB - 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("bp_stall_ready", in_ready, 0);
         chk("bp_stall_valid", out_valid, 1);
         chk("bp_stall_enable", out_enable, 4'b1111);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("sim_valid", out_valid, 1);
      chk("sim_enable", out_enable, 4'b1110);
      chk("sim_pt", out_pterm, 1);
      chk("sim_xfers1", xfers, 1);
      tick();
      chk("sim_xfers2", xfers, 2);
      for (int k = 2; k < TERMS; k++)
         for (int j = 0; j < NB; j++) send_bit(pat_bit(k, j));
      wait_done();
      tick();
      chk("bp_xfers", xfers, TERMS);

      // Reset mid-block then a clean block
      xfers = 0; done_cnt = 0;
      pulse_start();
      for (int b = 0; b < 12; b++) send_bit(pat_bit((((b / NB) * 5) + 3) & 15, b % NB));
      out_ready = 1'b0;
      send_bit(pat_bit(((3 * 5) + 3) & 15, 0));
      chk("mid_valid_before", out_valid, 1);
      chk("mid_busy_before", busy, 1);
      reset = 1'b1;
      tick();
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk("mid_rst_enable", out_enable, 0);
      chk("mid_rst_idx", {out_lab, out_macrocell, out_pterm}, 0);
      chk("mid_rst_done", done, 0);
      reset = 1'b0;
      out_ready = 1'b1;
      tick();
      xfers = 0; done_cnt = 0;
      pulse_start();
      for (int k = 0; k < TERMS; k++) begin
         for (int j = 0; j < NB; j++) send_bit(pat_bit(((k * 5) + 3) & 15, j));
         if (k == 0) begin
            chk("fresh_t0_enable", out_enable, 4'b1100);
            chk("fresh_t0_idx", {out_lab, out_macrocell, out_pterm}, 3'b000);
         end
      end
      wait_done();
      tick();
      chk("fresh_xfers", xfers, TERMS);
      chk("fresh_done_once", done_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
